// File: rtl/ecall_pkg.sv
// Shared constants for the ecall responder: service codes, FSM state encoding
// and the a0 write-back index.
package ecall_pkg;

   localparam logic [31:0] SVC_PRINT_INT = 32'd1;
   localparam logic [31:0] SVC_READ_INT  = 32'd5;
   localparam logic [31:0] SVC_EXIT      = 32'd10;
   localparam logic [4:0]  A0_IDX        = 5'd10;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PRINT     = 3'd1,
      ST_READ_WAIT = 3'd2,
      ST_DONE      = 3'd3,
      ST_HALT      = 3'd4
   } state_e;

   // Full 32-bit compare: anything outside the three known codes halts as BAD.
   function automatic state_e svc_target(input logic [31:0] code);
      state_e tgt;
      case (code)
         SVC_PRINT_INT: tgt = ST_PRINT;
         SVC_READ_INT:  tgt = ST_READ_WAIT;
         SVC_EXIT:      tgt = ST_HALT;
         default:       tgt = ST_HALT;
      endcase
      return tgt;
   endfunction

endpackage

// File: rtl/ecall_responder_if.sv
// Decode-stage / register-file side of the ecall responder: request inputs,
// stall back to the core and the a0 write-back port.
interface ecall_responder_if;

   logic        ecall_valid;
   logic [31:0] svc_code;
   logic [31:0] svc_arg;
   logic        stall;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   modport master (
      output ecall_valid, svc_code, svc_arg,
      input  stall, wb_en, wb_rd, wb_data
   );

   modport slave (
      input  ecall_valid, svc_code, svc_arg,
      output stall, wb_en, wb_rd, wb_data
   );

endinterface

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for the asynchronous confirm button, followed by a
// delay flop that turns a synchronised 0->1 transition into a one-cycle pulse.
module btn_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic btn_async,
   output logic rise
);

   // [0],[1]: synchroniser stages; [2]: previous synchronised level
   logic [2:0] sync_q, sync_d;

   always_comb begin
      sync_d = {sync_q[1:0], btn_async};
      rise   = sync_q[1] & ~sync_q[2];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= 3'b000;
      end else begin
         sync_q <= sync_d;
      end
   end

endmodule

// File: rtl/ecall_responder.sv
// Services print-int / read-int / exit ecalls from decode, stalling the core
// meanwhile. Optional ECALL_PRINT_HOLD_EN keeps PRINT active for HOLD_CYCLES.
module ecall_responder
   import ecall_pkg::*;
#(
   parameter int SW_WIDTH    = 16,
   parameter int HOLD_CYCLES = 1000
) (
   input  logic                clk,
   input  logic                rst,
   ecall_responder_if.slave    bus,
   input  logic [SW_WIDTH-1:0] sw,
   input  logic                confirm_btn,
   output logic [31:0]         disp_value,
   output logic                disp_valid,
   output logic                halted,
   output logic                err
);

   if (HOLD_CYCLES < 1) begin : g_bad_hold
      $error("HOLD_CYCLES must be at least 1");
   end

   state_e      state_q, state_d;
   logic [31:0] disp_value_q, disp_value_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic        disp_valid_q, disp_valid_d;
   logic        wb_en_q, wb_en_d;
   logic        halted_q, halted_d;
   logic        err_q, err_d;
   logic        stall_c;
   logic        btn_rise;
   logic        enter_print, enter_halt, read_hit;

   btn_sync_edge u_btn (
      .clk       (clk),
      .rst       (rst),
      .btn_async (confirm_btn),
      .rise      (btn_rise)
   );

`ifdef ECALL_PRINT_HOLD_EN
   localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

   always_comb begin
      hold_cnt_d = hold_cnt_q;
      if (enter_print) begin
         hold_cnt_d = CNT_W'(HOLD_CYCLES - 1);
      end else if (state_q == ST_PRINT && hold_cnt_q != {CNT_W{1'b0}}) begin
         hold_cnt_d = hold_cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         hold_cnt_d = hold_cnt_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_cnt_q <= {CNT_W{1'b0}};
      end else begin
         hold_cnt_q <= hold_cnt_d;
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.ecall_valid) begin
               state_d = svc_target(bus.svc_code);
            end else begin
               state_d = ST_IDLE;
            end
         end
`ifdef ECALL_PRINT_HOLD_EN
         ST_PRINT: begin
            if (hold_cnt_q == {CNT_W{1'b0}}) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_PRINT;
            end
         end
`else
         ST_PRINT:     state_d = ST_DONE;
`endif
         ST_READ_WAIT: begin
            if (btn_rise) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_READ_WAIT;
            end
         end
         ST_DONE:      state_d = ST_IDLE;
         ST_HALT:      state_d = ST_HALT;
         default:      state_d = ST_IDLE;
      endcase
   end

   // Registered outputs are loaded on the transition into the state that shows them.
   always_comb begin
      enter_print  = (state_q == ST_IDLE) && (state_d == ST_PRINT);
      enter_halt   = (state_q == ST_IDLE) && (state_d == ST_HALT);
      read_hit     = (state_q == ST_READ_WAIT) && btn_rise;
      disp_value_d = enter_print ? bus.svc_arg : disp_value_q;
      disp_valid_d = enter_print ? 1'b1 : disp_valid_q;
      wb_en_d      = read_hit;
      wb_data_d    = read_hit ? 32'($signed(sw)) : wb_data_q;
      halted_d     = enter_halt ? 1'b1 : halted_q;
      err_d        = enter_halt ? (bus.svc_code != SVC_EXIT) : err_q;
      stall_c      = ~rst & (((state_q == ST_IDLE) && bus.ecall_valid) ||
                             ((state_q != ST_IDLE) && (state_q != ST_DONE)));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         disp_value_q <= 32'd0;
         disp_valid_q <= 1'b0;
         wb_en_q      <= 1'b0;
         wb_data_q    <= 32'd0;
         halted_q     <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         disp_value_q <= disp_value_d;
         disp_valid_q <= disp_valid_d;
         wb_en_q      <= wb_en_d;
         wb_data_q    <= wb_data_d;
         halted_q     <= halted_d;
         err_q        <= err_d;
      end
   end

   assign bus.stall   = stall_c;
   assign bus.wb_en   = wb_en_q;
   assign bus.wb_rd   = A0_IDX;
   assign bus.wb_data = wb_data_q;
   assign disp_value  = disp_value_q;
   assign disp_valid  = disp_valid_q;
   assign halted      = halted_q;
   assign err         = err_q;

endmodule

// File: tb/tb_ecall_responder.sv
// Scoreboard bench for ecall_responder: the driver pushes the expected outcome
// of each ecall; a negedge monitor pops and compares when a service completes.
module tb_ecall_responder;

   localparam int HOLD = 8;
`ifdef ECALL_PRINT_HOLD_EN
   localparam int PRINT_STALL = HOLD + 1;
`else
   localparam int PRINT_STALL = 2;
`endif

   typedef enum int {K_PRINT, K_READ, K_HALT} kind_e;
   typedef struct {
      kind_e       kind;
      logic [31:0] value;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] sw;
   logic        confirm_btn;
   logic [31:0] disp_value;
   logic        disp_valid, halted, err;

   exp_t exp_q[$];
   int   checks = 0;
   int   fails  = 0;

   ecall_responder_if bus();

   ecall_responder #(.SW_WIDTH(16), .HOLD_CYCLES(HOLD)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .sw          (sw),
      .confirm_btn (confirm_btn),
      .disp_value  (disp_value),
      .disp_valid  (disp_valid),
      .halted      (halted),
      .err         (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, expv);
      end
   endtask

   // Reference: what an ecall should do, from the service table alone.
   function automatic exp_t model(input logic [31:0] code, input logic [31:0] arg, input logic [15:0] s);
      exp_t e;
      e.err   = 1'b0;
      e.value = 32'd0;
      if (code == 32'd1) begin
         e.kind  = K_PRINT;
         e.value = arg;
      end else if (code == 32'd5) begin
         e.kind  = K_READ;
         e.value = {16'h0000, s};
         if (s >= 16'h8000) e.value = e.value - 32'h0001_0000;
      end else begin
         e.kind = K_HALT;
         e.err  = (code != 32'd10);
      end
      return e;
   endfunction

   // Monitor: stall run length ends at a completion; halted rising ends a halt.
   int   run = 0;
   bit   halted_prev = 1'b0;
   bit   wb_chk = 1'b0;
   exp_t me;
   always @(negedge clk) begin
      if (rst) begin
         run = 0;
         halted_prev = 1'b0;
         wb_chk = 1'b0;
      end else begin
         if (wb_chk) check("wb_en_single_cycle", {31'd0, bus.wb_en}, 32'd0);
         wb_chk = 1'b0;
         if (halted && !halted_prev) begin
            if (exp_q.size() == 0) begin
               check("halt_unexpected", 32'd1, 32'd0);
            end else begin
               me = exp_q.pop_front();
               check("halt_kind", me.kind, K_HALT);
               check("halt_err", {31'd0, err}, {31'd0, me.err});
            end
         end
         halted_prev = halted;
         if (bus.stall) begin
            run++;
         end else if (run > 0) begin
            if (exp_q.size() == 0) begin
               check("completion_unexpected", 32'd1, 32'd0);
            end else begin
               me = exp_q.pop_front();
               if (me.kind == K_PRINT) begin
                  check("print_stall_len", run, PRINT_STALL);
                  check("print_disp_value", disp_value, me.value);
                  check("print_disp_valid", {31'd0, disp_valid}, 32'd1);
                  check("print_no_wb", {31'd0, bus.wb_en}, 32'd0);
               end else if (me.kind == K_READ) begin
                  check("read_stall_min", {31'd0, run >= 5}, 32'd1);
                  check("read_wb_en", {31'd0, bus.wb_en}, 32'd1);
                  check("read_wb_rd", {27'd0, bus.wb_rd}, 32'd10);
                  check("read_wb_data", bus.wb_data, me.value);
                  wb_chk = 1'b1;
               end else begin
                  check("halt_completed", 32'd1, 32'd0);
               end
            end
            run = 0;
         end else if (bus.wb_en) begin
            check("wb_en_spurious", 32'd1, 32'd0);
         end
      end
   end

   task automatic present(input logic [31:0] code, input logic [31:0] arg);
      bus.ecall_valid = 1'b1;
      bus.svc_code    = code;
      bus.svc_arg     = arg;
      exp_q.push_back(model(code, arg, sw));
   endtask

   // Waits for the stall-free DONE cycle, optionally pressing confirm on the way.
   task automatic wait_release(input int max, input bit press);
      int k = 0;
      bit done = 1'b0;
      while (!done && k < max) begin
         @(negedge clk);
         if (!bus.stall) begin
            done = 1'b1;
         end else begin
            k++;
            if (press && k == 3) confirm_btn = 1'b1;
         end
      end
      check("service_done", {31'd0, done}, 32'd1);
      @(posedge clk); #1;
      confirm_btn = 1'b0;
   endtask

   task automatic do_reset();
      check("queue_empty_before_reset", exp_q.size(), 32'd0);
      exp_q.delete();
      bus.ecall_valid = 1'b0;
      confirm_btn     = 1'b0;
      rst             = 1'b1;
      @(negedge clk);
      check("rst_stall", {31'd0, bus.stall}, 32'd0);
      check("rst_wb_en", {31'd0, bus.wb_en}, 32'd0);
      check("rst_wb_data", bus.wb_data, 32'd0);
      check("rst_wb_rd", {27'd0, bus.wb_rd}, 32'd10);
      check("rst_disp_value", disp_value, 32'd0);
      check("rst_disp_valid", {31'd0, disp_valid}, 32'd0);
      check("rst_halted", {31'd0, halted}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic halt_episode(input logic [31:0] code, input int hold);
      int lows = 0;
      present(code, $urandom);
      repeat (hold) begin
         @(negedge clk);
         if (!bus.stall) lows++;
      end
      check("halt_stall_held", lows, 32'd0);
      check("halt_level", {31'd0, halted}, 32'd1);
      @(posedge clk); #1;
      do_reset();
   endtask

   initial begin
      logic [31:0] bad_codes [4];
      int n_lows;
      bad_codes[0] = 32'h0000_0101;
      bad_codes[1] = 32'h0000_0000;
      bad_codes[2] = 32'h8000_0001;
      bad_codes[3] = 32'h0000_0105;
      rst = 1'b1;
      sw = 16'h0000;
      confirm_btn = 1'b0;
      bus.ecall_valid = 1'b0;
      bus.svc_code = 32'd0;
      bus.svc_arg = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      do_reset();

      // Print, then read of a negative switch value
      present(32'd1, 32'hDEAD_BEEF);
      wait_release(50, 1'b0);
      bus.ecall_valid = 1'b0;
      sw = 16'h8001;
      present(32'd5, 32'd0);
      wait_release(50, 1'b1);
      bus.ecall_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("wb_data_holds", bus.wb_data, 32'hFFFF_8001);
      check("disp_value_holds", disp_value, 32'hDEAD_BEEF);
      @(posedge clk); #1;

      // A button held before the read must not complete it
      confirm_btn = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      sw = 16'h1234;
      present(32'd5, 32'd0);
      repeat (20) @(negedge clk);
      check("held_btn_stalls", {31'd0, bus.stall}, 32'd1);
      confirm_btn = 1'b0;
      repeat (4) @(negedge clk);
      check("released_btn_stalls", {31'd0, bus.stall}, 32'd1);
      confirm_btn = 1'b1;
      wait_release(50, 1'b0);
      bus.ecall_valid = 1'b0;

      // Back-to-back print then read with ecall_valid never dropping
      present(32'd1, 32'h0000_0042);
      wait_release(50, 1'b0);
      sw = 16'h7FFF;
      present(32'd5, 32'd0);
      wait_release(50, 1'b1);
      bus.ecall_valid = 1'b0;

      // Randomized print/read traffic, mixing gaps and back-to-back issue
      for (int i = 0; i < 40; i++) begin
         sw = 16'($urandom);
         if ($urandom_range(1, 0) == 1) begin
            present(32'd1, $urandom);
            wait_release(50, 1'b0);
         end else begin
            present(32'd5, $urandom);
            wait_release(50, 1'b1);
         end
         if ($urandom_range(1, 0) == 1) begin
            bus.ecall_valid = 1'b0;
            repeat ($urandom_range(3, 0)) @(posedge clk);
            #1;
         end
      end
      bus.ecall_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Exit holds the core; BAD codes halt with err; reset recovers
      halt_episode(32'd10, 110);
      n_lows = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.stall || halted) n_lows++;
      end
      check("after_exit_reset_idle", n_lows, 32'd0);
      @(posedge clk); #1;
      for (int b = 0; b < 4; b++) begin
         halt_episode(bad_codes[b], 6 + b);
      end
      present(32'd1, 32'h0BAD_F00D);
      wait_release(50, 1'b0);
      bus.ecall_valid = 1'b0;

      repeat (3) @(posedge clk);
      check("queue_drained", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
